// File: rtl/if_fetch_buffer.sv
// First-word-fall-through fetch buffer between IF and ID; replaces the IF_ID register.
// Holds {InsAddr, nextPC4, Instruction}, flushes wrong-path entries, and stalls the PC when full.
module if_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic [31:0]   InsAddr,
  input  logic [31:0]   nextPC4,
  input  logic [31:0]   Instruction,
  input  logic          FetchValid,
  input  logic          Flush,
  input  logic          ID_Ready,
  output logic          PCWrite_HD,
  output logic          ID_Valid,
  output logic [31:0]   ID_Instr,
  output logic [31:0]   ID_PC,
  output logic [31:0]   outnextPC4,
  output logic [AW:0]   Count,
  output logic          Empty,
  output logic          Full,
  output logic [15:0]   FlushDropped
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetchEntry_t;

  fetchEntry_t       mem [DEPTH];
  fetchEntry_t       head;
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [AW:0]       cnt;
  logic [15:0]       flushDropped;
  logic              fetchKeep, push, pop;
  logic [16:0]       dropSum;

  assign Empty      = (cnt == '0);
  assign Full       = (cnt == (AW+1)'(DEPTH));
  assign PCWrite_HD = ~Full;
  assign ID_Valid   = ~Empty;
  assign Count      = cnt;
  assign FlushDropped = flushDropped;

  // A fetch that would have been stored if no flush were pending; it counts as dropped on a flush.
  assign fetchKeep = FetchValid & ~Full;
  assign push      = fetchKeep & ~Flush;
  assign pop       = ID_Valid & ID_Ready & ~Flush;
  assign dropSum   = {1'b0, flushDropped} + 17'(cnt) + 17'(fetchKeep);

  assign head       = mem[rdPtr];
  assign ID_Instr   = Empty ? 32'h0 : head.instr;
  assign ID_PC      = Empty ? 32'h0 : head.addr;
  assign outnextPC4 = Empty ? 32'h0 : head.pc4;

  // NOTE: storage has no reset; the pointers and count alone decide what is valid, so stale data is never seen.
  always_ff @(negedge CLK) begin
    if (push) mem[wrPtr] <= '{addr: InsAddr, pc4: nextPC4, instr: Instruction};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge CLK or negedge Reset) begin
    if (!Reset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      cnt          <= '0;
      flushDropped <= '0;
    end else if (Flush) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      cnt          <= '0;
      flushDropped <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- First-word-fall-through FIFO between instruction fetch and the ID stage. It replaces the plain IF_ID register.
- Captures {InsAddr, nextPC4, Instruction} for each fetched instruction and presents the oldest entry to decode.
- Flushes wrong-path entries when a branch, jump or jr is taken.
- Drives PCWrite_HD back to the PC so fetch stalls when the buffer is full.

Parameters:
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- AW, 2: pointer width, equal to log2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the falling edge.
- Reset  in  1  reset, asynchronous, active-low.
- InsAddr  in  32  address of the instruction being fetched this cycle.
- nextPC4  in  32  InsAddr + 4.
- Instruction  in  32  instruction-memory read data for InsAddr.
- FetchValid  in  1  fetch slot is real this cycle (PCWrite_C).
- Flush  in  1  taken branch/jump/jr; discard all buffered entries.
- ID_Ready  in  1  ID stage accepts the head entry this cycle (0 = load-use stall).
- PCWrite_HD  out  1  1 = PC may advance; equals ~Full.
- ID_Valid  out  1  head entry present; equals ~Empty.
- ID_Instr  out  32  head instruction; 32'h0 (nop) when empty.
- ID_PC  out  32  head InsAddr; 0 when empty.
- outnextPC4  out  32  head nextPC4; 0 when empty.
- Count  out  AW+1  number of occupied entries, 0..DEPTH.
- Empty  out  1  Count == 0.
- Full  out  1  Count == DEPTH.
- FlushDropped  out  16  saturating count of valid entries discarded by flushes.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - Immediately clears wr_ptr, rd_ptr, Count and FlushDropped; storage contents are don't-care.
  - Outputs become Empty = 1, Full = 0, PCWrite_HD = 1, ID_Valid = 0, and ID_Instr, ID_PC, outnextPC4 = 0.
  - A reset asserted mid-operation discards all entries with no partial update.
- Event definitions:
  - push = FetchValid & ~Full & ~Flush.
  - pop = ID_Valid & ID_Ready & ~Flush.
- Falling-edge update, with Flush having top priority:
  - Flush = 1: wr_ptr, rd_ptr and Count go to 0, and the entry fetched this cycle is dropped (wrong path). FlushDropped += Count + (FetchValid & ~Full), saturating at 16'hFFFF.
  - Otherwise, if push: store the entry at mem[wr_ptr], wr_ptr++.
  - Otherwise, if pop: rd_ptr++.
  - Count += push - pop; a simultaneous push and pop leaves Count unchanged.
- Pointers wrap modulo DEPTH through natural AW-bit overflow.
- Head outputs are combinational reads of mem[rd_ptr], masked to 0 when Empty.
  - An entry pushed on edge N is visible on ID_* after edge N (1-edge latency through an empty buffer).
- Full handling:
  - PCWrite_HD = ~Full and depends only on registered state, so there is no combinational path from ID_Ready.
  - When Full, push is blocked even if pop happens in the same cycle; the PC is stalled by PCWrite_HD = 0, so no entry is lost.
  - FetchValid = 1 while Full is ignored, not written.
- Empty handling:
  - ID_Valid = 0 and ID_Instr = nop.
  - ID_Ready is ignored; pop cannot occur.
- Flush while empty: state unchanged, FlushDropped unchanged unless a fetch was dropped.
- Ordering: entries leave strictly in push order; no reordering, no duplication.

Test Plan:
- Reset release with FetchValid = 0 -> Empty = 1, PCWrite_HD = 1, ID_Instr = 0, Count = 0, FlushDropped = 0.
- Push PC 0x00, 0x04, 0x08, 0x0C with ID_Ready = 0 -> Count 1..4, Full = 1, PCWrite_HD = 0. A fifth fetch at 0x10 is ignored; ID_PC = 0x00, outnextPC4 = 0x04.
- From full, ID_Ready = 1 with FetchValid = 0 for 4 cycles -> ID_PC sequence 0x00, 0x04, 0x08, 0x0C, then Empty = 1, ID_Instr = 0.
- Steady stream with FetchValid = 1 and ID_Ready = 1 for 10 cycles starting at PC 0x20 -> Count stays 1, ID_PC advances by 4 each edge, pointers wrap past index 3 with no data loss.
- Three entries buffered, FetchValid = 1, Flush = 1 for one edge -> Count = 0, Empty = 1, FlushDropped = 4. The next fetch at branch target 0x100 appears as ID_PC = 0x100 after one edge.
- Two entries buffered, Reset pulsed low between edges -> outputs zero immediately, before the next clock edge, and the old entries never reappear.
